// File: rtl/l2_bus_pkg.sv
// l2_bus_pkg: op/snoop codes, FSM states and line alignment for the L2 bus request queue
package l2_bus_pkg;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_RFO, OP_INVALIDATE} op_e;
    typedef enum logic [1:0] {SN_NOHIT, SN_HIT, SN_HITM, SN_RSVD} snoop_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
    function automatic logic [63:0] line_align(input logic [63:0] a, input int off);
        return a & ~((64'd1 << off) - 64'd1);
    endfunction
endpackage

// File: rtl/l2_bus_request_queue_if.sv
// l2_bus_request_queue_if: controller request, system bus and completion signals of the queue
interface l2_bus_request_queue_if #(parameter int ADDR_W = 32, parameter int CNT_W = 32);
    logic req_valid, req_ready;
    logic [1:0] req_op;
    logic [ADDR_W-1:0] req_addr;
    logic bus_valid, bus_ack;
    logic [1:0] bus_op, bus_snoop;
    logic [ADDR_W-1:0] bus_addr;
    logic rsp_valid, rsp_ready, rsp_err;
    logic [1:0] rsp_op, rsp_snoop;
    logic [ADDR_W-1:0] rsp_addr;
    logic [CNT_W-1:0] cnt_read, cnt_write, cnt_modify, cnt_invalid;
    modport master (
        input req_valid, req_op, req_addr, bus_ack, bus_snoop, rsp_ready,
        output req_ready, bus_valid, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr, rsp_snoop, rsp_err,
        output cnt_read, cnt_write, cnt_modify, cnt_invalid
    );
    modport slave (
        output req_valid, req_op, req_addr, bus_ack, bus_snoop, rsp_ready,
        input req_ready, bus_valid, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr, rsp_snoop, rsp_err,
        input cnt_read, cnt_write, cnt_modify, cnt_invalid
    );
endinterface

// File: rtl/l2_req_fifo.sv
// l2_req_fifo: synchronous power-of-two FIFO with full/empty flags
module l2_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic [W-1:0] din,
    input  logic pop,
    output logic [W-1:0] dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign dout = mem[rp];
    assign full = cnt == FULL_CNT;
    assign empty = cnt == '0;
endmodule

// File: rtl/l2_bus_request_queue.sv
// l2_bus_request_queue: buffers L2 bus ops, issues one at a time with a timeout, returns snoop completions
module l2_bus_request_queue import l2_bus_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int OFFSET_W = 6,
    parameter int DEPTH = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    l2_bus_request_queue_if.master q
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    state_e state, state_nx;
    logic up, push, pop, ack, full, empty, err;
    logic [1:0] head_op, snoop, snoop_nx;
    logic [ADDR_W-1:0] head_addr;
    logic [WD_W-1:0] wdog;
    logic [CNT_W-1:0] cnt [4];
    assign push = q.req_valid && q.req_ready;
    assign pop = state == S_RESP && q.rsp_ready;
    assign ack = state == S_ISSUE && q.bus_ack;
    assign q.req_ready = up && !full;
    l2_req_fifo #(.DEPTH(DEPTH), .W(2 + ADDR_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din({q.req_op, ADDR_W'(line_align(64'(q.req_addr), OFFSET_W))}),
        .pop(pop),
        .dout({head_op, head_addr}),
        .full(full),
        .empty(empty)
    );
    // Only reads and RFOs carry a meaningful snoop; the reserved code reads as no hit.
    assign snoop_nx = ((head_op == OP_READ || head_op == OP_RFO) && q.bus_snoop != SN_RSVD) ? q.bus_snoop : SN_NOHIT;
    always_comb begin
        state_nx = state == S_IDLE  ? (empty ? S_IDLE : S_ISSUE)
                 : state == S_ISSUE ? ((ack || wdog == WD_LAST) ? S_RESP : S_ISSUE)
                 : pop ? S_IDLE : S_RESP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            up <= 1'b0;
            wdog <= '0;
            snoop <= '0;
            err <= 1'b0;
            cnt <= '{default: '0};
        end else begin
            up <= 1'b1;
            state <= state_nx;
            if (ack) begin
                snoop <= snoop_nx;
                err <= 1'b0;
                cnt[head_op] <= cnt[head_op] + CNT_W'(1);
            end else if (state == S_ISSUE) begin
                wdog <= wdog + WD_W'(1);
                if (wdog == WD_LAST) begin
                    snoop <= SN_NOHIT;
                    err <= 1'b1;
                end
            end
            if (pop) wdog <= '0;
        end
    end
    assign q.bus_valid = state == S_ISSUE;
    assign q.bus_op = q.bus_valid ? head_op : 2'd0;
    assign q.bus_addr = q.bus_valid ? head_addr : '0;
    assign q.rsp_valid = state == S_RESP;
    assign q.rsp_op = q.rsp_valid ? head_op : 2'd0;
    assign q.rsp_addr = q.rsp_valid ? head_addr : '0;
    assign q.rsp_snoop = q.rsp_valid ? snoop : 2'd0;
    assign q.rsp_err = q.rsp_valid && err;
    assign q.cnt_read = cnt[0];
    assign q.cnt_write = cnt[1];
    assign q.cnt_modify = cnt[2];
    assign q.cnt_invalid = cnt[3];
endmodule

// File: tb/tb_l2_bus_request_queue.sv
// tb_l2_bus_request_queue: vector table, corner sequences and a randomized transaction-level model
module tb_l2_bus_request_queue;
    import l2_bus_pkg::*;
    localparam int TIMEOUT = 15;
    localparam int DEPTH = 4;
    typedef struct {
        logic [1:0] op;
        logic [31:0] addr;
        logic [1:0] sn;
        int dly;
        logic [31:0] ea;
        logic [1:0] esn;
        bit eerr;
    } vec_t;
    typedef struct {
        logic [1:0] op;
        logic [31:0] a;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    l2_bus_request_queue_if #(.ADDR_W(32), .CNT_W(32)) q ();
    l2_bus_request_queue #(.ADDR_W(32), .OFFSET_W(6), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .q(q)
    );
    always #5 clk = ~clk;
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not terminate");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endtask

    task automatic chk_cnt(input string n, input int r, input int w, input int m, input int v);
        chk({n, "_cnt_read"}, q.cnt_read, r);
        chk({n, "_cnt_write"}, q.cnt_write, w);
        chk({n, "_cnt_modify"}, q.cnt_modify, m);
        chk({n, "_cnt_invalid"}, q.cnt_invalid, v);
    endtask

    task automatic do_reset();
        q.req_valid = 0;
        q.req_op = 0;
        q.req_addr = 0;
        q.bus_ack = 0;
        q.bus_snoop = 0;
        q.rsp_ready = 0;
        rst = 1;
        step();
        step();
        chk("rst_req_ready", q.req_ready, 0);
        chk("rst_bus_valid", q.bus_valid, 0);
        chk("rst_rsp_valid", q.rsp_valid, 0);
        chk("rst_rsp_err", q.rsp_err, 0);
        chk_cnt("rst", 0, 0, 0, 0);
        rst = 0;
        step();
        chk("rst_ready_after", q.req_ready, 1);
    endtask

    // Issue the head with `dly` idle cycles before ack (large dly means never ack), then consume the completion.
    task automatic serve(input logic [1:0] op, input logic [31:0] a, input logic [1:0] sn, input int dly,
                         input logic [1:0] esn, input bit eerr, input string n);
        int nv = 0;
        for (int w = 0; w < 20 && !q.bus_valid; w++) step();
        chk({n, "_bus_valid"}, q.bus_valid, 1);
        while (q.bus_valid && nv < 40) begin
            chk({n, "_bus_op"}, q.bus_op, op);
            chk({n, "_bus_addr"}, q.bus_addr, a);
            q.bus_ack = (nv == dly);
            q.bus_snoop = sn;
            nv++;
            step();
            q.bus_ack = 0;
        end
        chk({n, "_valid_cycles"}, nv, (dly + 1 < TIMEOUT) ? dly + 1 : TIMEOUT);
        chk({n, "_rsp_valid"}, q.rsp_valid, 1);
        chk({n, "_rsp_op"}, q.rsp_op, op);
        chk({n, "_rsp_addr"}, q.rsp_addr, a);
        chk({n, "_rsp_snoop"}, q.rsp_snoop, esn);
        chk({n, "_rsp_err"}, q.rsp_err, eerr);
        q.bus_ack = 1;
        q.bus_snoop = 2'd1;
        step();
        q.bus_ack = 0;
        chk({n, "_rsp_hold"}, q.rsp_valid, 1);
        chk({n, "_snoop_hold"}, q.rsp_snoop, esn);
        chk({n, "_bus_quiet"}, q.bus_valid, 0);
        q.rsp_ready = 1;
        step();
        q.rsp_ready = 0;
        chk({n, "_rsp_drop"}, q.rsp_valid, 0);
    endtask

    initial begin
        vec_t tbl [7];
        ent_t mq [$];
        int mcnt [4];
        int nv, gap;
        bit pend, eerr, dead, issuing, push, pop;
        logic [1:0] esn;
        tbl[0] = '{OP_READ,       32'h0000_1234, 2'd2, 3,  32'h0000_1200, 2'd2, 1'b0};
        tbl[1] = '{OP_READ,       32'h8000_007F, 2'd1, 0,  32'h8000_0040, 2'd1, 1'b0};
        tbl[2] = '{OP_RFO,        32'hDEAD_BEEF, 2'd1, 1,  32'hDEAD_BEC0, 2'd1, 1'b0};
        tbl[3] = '{OP_INVALIDATE, 32'h0000_0040, 2'd2, 2,  32'h0000_0040, 2'd0, 1'b0};
        tbl[4] = '{OP_WRITE,      32'hFFFF_FFFF, 2'd1, 0,  32'hFFFF_FFC0, 2'd0, 1'b0};
        tbl[5] = '{OP_READ,       32'h1234_5678, 2'd3, 14, 32'h1234_5640, 2'd0, 1'b0};
        tbl[6] = '{OP_RFO,        32'h0000_1000, 2'd2, 99, 32'h0000_1000, 2'd0, 1'b1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            q.req_valid = 1;
            q.req_op = tbl[i].op;
            q.req_addr = tbl[i].addr;
            step();
            q.req_valid = 0;
            chk($sformatf("t%0d_lat1", i), q.bus_valid, 0);
            step();
            chk($sformatf("t%0d_lat2", i), q.bus_valid, 1);
            serve(tbl[i].op, tbl[i].ea, tbl[i].sn, tbl[i].dly, tbl[i].esn, tbl[i].eerr, $sformatf("t%0d", i));
        end
        chk_cnt("table", 3, 1, 1, 1);

        // Fill to full, then a fifth request waits for the first completion.
        do_reset();
        q.req_valid = 1;
        q.req_op = OP_WRITE;
        for (int i = 0; i < 4; i++) begin
            q.req_addr = 32'h100 * (i + 1);
            chk($sformatf("fill_ready%0d", i), q.req_ready, 1);
            step();
        end
        chk("fill_full", q.req_ready, 0);
        q.req_addr = 32'h500;
        step();
        step();
        chk("fill_blocked", q.req_ready, 0);
        chk("fill_head", q.bus_addr, 32'h100);
        q.bus_ack = 1;
        q.bus_snoop = 2'd2;
        step();
        q.bus_ack = 0;
        chk("fill_rsp_addr", q.rsp_addr, 32'h100);
        chk("fill_rsp_snoop", q.rsp_snoop, 0);
        chk("fill_no_bypass", q.req_ready, 0);
        q.rsp_ready = 1;
        step();
        q.rsp_ready = 0;
        chk("fill_after_pop", q.req_ready, 1);
        step();
        q.req_valid = 0;
        chk("fill_full_again", q.req_ready, 0);
        for (int i = 2; i <= 5; i++)
            serve(OP_WRITE, 32'h100 * i, 2'd2, i - 2, 2'd0, 1'b0, $sformatf("fill%0d", i));
        chk_cnt("fill", 0, 5, 0, 0);

        // Simultaneous push and pop keeps occupancy at two.
        q.req_valid = 1;
        q.req_op = OP_READ;
        q.req_addr = 32'hA000;
        step();
        q.req_addr = 32'hB000;
        step();
        q.req_valid = 0;
        for (int w = 0; w < 20 && !q.bus_valid; w++) step();
        chk("pp_head", q.bus_addr, 32'hA000);
        q.bus_ack = 1;
        q.bus_snoop = 2'd1;
        step();
        q.bus_ack = 0;
        chk("pp_rsp_addr", q.rsp_addr, 32'hA000);
        q.rsp_ready = 1;
        q.req_valid = 1;
        q.req_addr = 32'hC000;
        step();
        q.rsp_ready = 0;
        chk("pp_rsp_drop", q.rsp_valid, 0);
        chk("pp_ready2", q.req_ready, 1);
        q.req_addr = 32'hD000;
        step();
        chk("pp_ready3", q.req_ready, 1);
        q.req_addr = 32'hE000;
        step();
        q.req_valid = 0;
        chk("pp_full4", q.req_ready, 0);
        for (int i = 0; i < 4; i++)
            serve(OP_READ, 32'hB000 + 32'h1000 * i, 2'd1, 0, 2'd1, 1'b0, $sformatf("pp%0d", i));
        chk_cnt("pp", 5, 5, 0, 0);

        // Reset while a transaction is on the bus with entries queued.
        q.req_valid = 1;
        q.req_op = OP_RFO;
        for (int i = 0; i < 3; i++) begin
            q.req_addr = 32'h1_0000 + 32'h40 * i;
            step();
        end
        q.req_valid = 0;
        for (int w = 0; w < 20 && !q.bus_valid; w++) step();
        chk("mid_bus_valid", q.bus_valid, 1);
        rst = 1;
        step();
        chk("mid_bus_drop", q.bus_valid, 0);
        chk("mid_rsp_drop", q.rsp_valid, 0);
        chk("mid_ready_low", q.req_ready, 0);
        chk_cnt("mid", 0, 0, 0, 0);
        rst = 0;
        step();
        chk("mid_ready", q.req_ready, 1);
        step();
        step();
        chk("mid_empty", q.bus_valid, 0);

        // Randomized traffic against a transaction-level queue model.
        do_reset();
        mcnt = '{0, 0, 0, 0};
        nv = 0;
        gap = 0;
        pend = 0;
        eerr = 0;
        dead = 0;
        esn = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_req_ready", q.req_ready, mq.size() < DEPTH);
            chk("rnd_rsp_valid", q.rsp_valid, pend);
            if (q.bus_valid) begin
                if (mq.size() == 0 || pend) chk("rnd_bus_spurious", q.bus_valid, 0);
                else begin
                    chk("rnd_bus_op", q.bus_op, mq[0].op);
                    chk("rnd_bus_addr", q.bus_addr, mq[0].a);
                end
            end
            if (q.rsp_valid && pend) begin
                chk("rnd_rsp_op", q.rsp_op, mq[0].op);
                chk("rnd_rsp_addr", q.rsp_addr, mq[0].a);
                chk("rnd_rsp_snoop", q.rsp_snoop, esn);
                chk("rnd_rsp_err", q.rsp_err, eerr);
            end
            gap = (!pend && mq.size() > 0 && !q.bus_valid) ? gap + 1 : 0;
            if (gap > 1) chk("rnd_issue_gap", gap, 1);
            chk_cnt("rnd", mcnt[0], mcnt[1], mcnt[2], mcnt[3]);
            if (q.bus_valid && nv == 0) dead = $urandom_range(0, 5) == 0;
            q.req_valid = $urandom_range(0, 1);
            q.req_op = 2'($urandom_range(0, 3));
            q.req_addr = $urandom;
            q.rsp_ready = $urandom_range(0, 2) != 0;
            q.bus_ack = !dead && $urandom_range(0, 3) == 0;
            q.bus_snoop = 2'($urandom_range(0, 3));
            push = q.req_valid && mq.size() < DEPTH;
            pop = pend && q.rsp_ready;
            issuing = q.bus_valid && !pend && mq.size() > 0;
            if (pop) begin
                void'(mq.pop_front());
                pend = 0;
            end else if (issuing) begin
                if (q.bus_ack) begin
                    pend = 1;
                    eerr = 0;
                    esn = ((mq[0].op == OP_READ || mq[0].op == OP_RFO) && q.bus_snoop != 2'd3) ? q.bus_snoop : 2'd0;
                    mcnt[mq[0].op]++;
                    nv = 0;
                    dead = 0;
                end else if (++nv == TIMEOUT) begin
                    pend = 1;
                    eerr = 1;
                    esn = 0;
                    nv = 0;
                    dead = 0;
                end
            end
            if (push) mq.push_back('{q.req_op, q.req_addr & 32'hFFFF_FFC0});
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
